spike_rate_encoder: RTL and testbench

//  Rate-codes a vector of NUM_CH unsigned intensities into Bernoulli spike trains over num_steps timesteps.
//  Per-channel spike probability per step is intensity/2^DATA_W.

---
 rtl/spike_rate_encoder.sv | 163 ++++++++++++++++
 tb/tb_spike_rate_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns NUM_CH unsigned intensities into Bernoulli spike trains,
// one registered spike vector per accepted step_en strobe.
module spike_rate_encoder #(
   parameter int          NUM_CH    = 8,
   parameter int          DATA_W    = 8,
   parameter int          STEP_W    = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pixel_valid,
   output logic                       pixel_ready,
   input  logic [NUM_CH*DATA_W-1:0]   pixel_data,
   input  logic [STEP_W-1:0]          num_steps,
   input  logic                       step_en,
   input  logic                       clear,
   output logic [NUM_CH-1:0]          spike_out,
   output logic                       spike_valid,
   output logic                       busy,
   output logic                       done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit 16 = MSB).
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      lfsr_next = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
   endfunction

   logic [1:0]               state_r;
   logic [1:0]               next_state_s;
   logic [STEP_W-1:0]        step_cnt_r;
   logic [STEP_W-1:0]        num_steps_r;
   logic [NUM_CH*DATA_W-1:0] data_r;
   logic [15:0]              lfsr_r [NUM_CH];
   logic [NUM_CH-1:0]        spike_s;
   logic [NUM_CH-1:0]        spike_out_r;
   logic                     spike_valid_r;
   logic                     pixel_ready_r;
   logic                     busy_r;
   logic                     done_r;
   logic                     accept_s;
   logic                     step_fire_s;
   logic [STEP_W:0]          step_cnt_inc_s;
   logic                     last_step_s;

   assign pixel_ready = pixel_ready_r;
   assign spike_out   = spike_out_r;
   assign spike_valid = spike_valid_r;
   assign busy        = busy_r;
   assign done        = done_r;

   // Handshake, step qualification and final-step detection.
   always_comb begin
      accept_s       = pixel_valid && pixel_ready_r && (state_r == ST_IDLE) && !clear;
      step_fire_s    = step_en && (state_r == ST_RUN) && !clear;
      step_cnt_inc_s = {1'b0, step_cnt_r} + {{STEP_W{1'b0}}, 1'b1};
      last_step_s    = (step_cnt_inc_s == {1'b0, num_steps_r});
   end

   // Next-state logic; clear overrides every other request.
   always_comb begin
      next_state_s = state_r;
      if (clear) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (num_steps == {STEP_W{1'b0}}) begin
                     next_state_s = ST_DONE;
                  end else begin
                     next_state_s = ST_RUN;
                  end
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (step_fire_s && last_step_s) begin
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_RUN;
               end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
         endcase
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         // Spike when intensity strictly exceeds the low DATA_W bits of the channel LFSR.
         assign spike_s[g] = data_r[g*DATA_W +: DATA_W] > lfsr_r[g][DATA_W-1:0];

         // Per-channel LFSR; advances only on accepted steps and survives clear.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               lfsr_r[g] <= LFSR_SEED ^ 16'(g + 1);
            end else if (step_fire_s) begin
               lfsr_r[g] <= lfsr_next(lfsr_r[g]);
            end else begin
               lfsr_r[g] <= lfsr_r[g];
            end
         end
      end
   endgenerate

   // State register and status outputs, all derived from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         pixel_ready_r <= 1'b1;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= next_state_s;
         pixel_ready_r <= (next_state_s == ST_IDLE);
         busy_r        <= (next_state_s == ST_RUN);
         done_r        <= (next_state_s == ST_DONE);
      end
   end

   // Sample capture and step counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_r      <= {(NUM_CH*DATA_W){1'b0}};
         num_steps_r <= {STEP_W{1'b0}};
         step_cnt_r  <= {STEP_W{1'b0}};
      end else if (clear) begin
         step_cnt_r  <= {STEP_W{1'b0}};
      end else if (accept_s) begin
         data_r      <= pixel_data;
         num_steps_r <= num_steps;
         step_cnt_r  <= {STEP_W{1'b0}};
      end else if (step_fire_s) begin
         // The final step stops at num_steps, so the counter cannot wrap.
         step_cnt_r  <= step_cnt_inc_s[STEP_W-1:0];
      end else begin
         step_cnt_r  <= step_cnt_r;
      end
   end

   // Spike vector register; holds its value between steps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spike_out_r   <= {NUM_CH{1'b0}};
         spike_valid_r <= 1'b0;
      end else begin
         spike_valid_r <= step_fire_s;
         if (step_fire_s) begin
            spike_out_r <= spike_s;
         end else begin
            spike_out_r <= spike_out_r;
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed self-checking bench for spike_rate_encoder with an independent
// per-channel LFSR reference to predict every spike vector.
module tb_spike_rate_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [63:0] pixel_data;
   logic [7:0]  num_steps;
   logic        step_en;
   logic        clear;
   logic [7:0]  spike_out;
   logic        spike_valid;
   logic        busy;
   logic        done;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] mdl [8];

   always #5 clk = ~clk;

   spike_rate_encoder dut (
      .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .pixel_data(pixel_data), .num_steps(num_steps), .step_en(step_en), .clear(clear),
      .spike_out(spike_out), .spike_valid(spike_valid), .busy(busy), .done(done)
   );

   task automatic reseed_model();
      for (int i = 0; i < 8; i++) mdl[i] = 16'hACE1 ^ 16'(i + 1);
   endtask

   function automatic logic [7:0] predict(input logic [63:0] d);
      logic [7:0] r;
      logic [7:0] inten;
      logic [7:0] rnd;
      for (int i = 0; i < 8; i++) begin
         inten = d[i*8 +: 8];
         rnd   = mdl[i][7:0];
         r[i]  = (inten > rnd);
      end
      return r;
   endfunction

   task automatic advance_model();
      logic fb;
      for (int i = 0; i < 8; i++) begin
         fb     = mdl[i][15] ^ mdl[i][13] ^ mdl[i][12] ^ mdl[i][10];
         mdl[i] = {mdl[i][14:0], fb};
      end
   endtask

   task automatic load(input logic [63:0] d, input logic [7:0] n);
      @(negedge clk);
      pixel_data  = d;
      num_steps   = n;
      pixel_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      pixel_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; pixel_valid = 1'b0; pixel_data = 64'h0; num_steps = 8'd0;
      step_en = 1'b0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({pixel_ready, busy, spike_out, spike_valid, done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_state: got rdy=%b busy=%b so=%h sv=%b done=%b, expected rdy=1 busy=0 so=00 sv=0 done=0",
                  pixel_ready, busy, spike_out, spike_valid, done);
      end
      @(negedge clk);
      reset = 1'b0;
      reseed_model();
   endtask

   task automatic test_zero_intensity();
      int pulses = 0;
      logic [7:0] exp_s;
      load(64'h0, 8'd10);
      vectors++;
      if ({busy, pixel_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL zero_load: got busy=%b rdy=%b, expected busy=1 rdy=0", busy, pixel_ready);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); step_en = 1'b1;
         @(posedge clk); #1;
         exp_s = predict(64'h0);
         advance_model();
         if (spike_valid === 1'b1) pulses++;
         vectors++;
         if ({spike_valid, spike_out, done} !== {1'b1, exp_s, (k == 9)}) begin
            miscompares++;
            $display("FAIL zero_step%0d: got sv=%b so=%h done=%b, expected sv=1 so=%h done=%b",
                     k, spike_valid, spike_out, done, exp_s, (k == 9));
         end
      end
      @(negedge clk); step_en = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({done, pixel_ready, spike_valid} !== 3'b010 || pulses != 10) begin
         miscompares++;
         $display("FAIL zero_end: got done=%b rdy=%b sv=%b pulses=%0d, expected done=0 rdy=1 sv=0 pulses=10",
                  done, pixel_ready, spike_valid, pulses);
      end
   endtask

   task automatic test_full_ch0();
      int ch0 = 0;
      logic [7:0] exp_s;
      load(64'h0000_0000_0000_00FF, 8'd255);
      for (int k = 0; k < 255; k++) begin
         @(negedge clk); step_en = 1'b1;
         @(posedge clk); #1;
         exp_s = predict(64'h0000_0000_0000_00FF);
         advance_model();
         if (spike_out[0] === 1'b1 && spike_valid === 1'b1) ch0++;
         vectors++;
         if ({spike_valid, spike_out, done} !== {1'b1, exp_s, (k == 254)}) begin
            miscompares++;
            $display("FAIL full_step%0d: got sv=%b so=%h done=%b, expected sv=1 so=%h done=%b",
                     k, spike_valid, spike_out, done, exp_s, (k == 254));
         end
      end
      @(negedge clk); step_en = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (ch0 < 250 || pixel_ready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL full_end: got ch0=%0d rdy=%b done=%b, expected ch0>=250 rdy=1 done=0",
                  ch0, pixel_ready, done);
      end
   endtask

   task automatic test_zero_steps();
      @(negedge clk);
      pixel_data = 64'hFFFF_FFFF_FFFF_FFFF; num_steps = 8'd0; pixel_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({done, busy, pixel_ready, spike_valid} !== 4'b1000) begin
         miscompares++;
         $display("FAIL zsteps_done: got done=%b busy=%b rdy=%b sv=%b, expected done=1 busy=0 rdy=0 sv=0",
                  done, busy, pixel_ready, spike_valid);
      end
      @(negedge clk); pixel_valid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({done, pixel_ready, spike_valid} !== 3'b010) begin
         miscompares++;
         $display("FAIL zsteps_idle: got done=%b rdy=%b sv=%b, expected done=0 rdy=1 sv=0",
                  done, pixel_ready, spike_valid);
      end
   endtask

   task automatic test_sparse();
      logic [63:0] d = 64'h00FF_40C0_8010_2001;
      logic [7:0]  exp_s;
      load(d, 8'd4);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         step_en = 1'b1; pixel_data = ~d ^ 64'(k); pixel_valid = (k < 3);
         @(posedge clk); #1;
         exp_s = predict(d);
         advance_model();
         vectors++;
         if ({spike_valid, spike_out, done} !== {1'b1, exp_s, (k == 3)}) begin
            miscompares++;
            $display("FAIL sparse_step%0d: got sv=%b so=%h done=%b, expected sv=1 so=%h done=%b",
                     k, spike_valid, spike_out, done, exp_s, (k == 3));
         end
         for (int gap = 0; gap < 2; gap++) begin
            @(negedge clk); step_en = 1'b0; pixel_valid = 1'b0;
            @(posedge clk); #1;
            vectors++;
            if (spike_valid !== 1'b0 || spike_out !== exp_s || busy !== (k < 3)) begin
               miscompares++;
               $display("FAIL sparse_gap%0d_%0d: got sv=%b so=%h busy=%b, expected sv=0 so=%h busy=%b",
                        k, gap, spike_valid, spike_out, busy, exp_s, (k < 3));
            end
         end
      end
   endtask

   task automatic test_clear();
      logic [63:0] d  = 64'h8080_8080_8080_8080;
      logic [63:0] d2 = 64'h0123_4567_89AB_CDEF;
      logic [7:0]  exp_s;
      load(d, 8'd5);
      @(negedge clk); step_en = 1'b1;
      @(posedge clk); #1;
      exp_s = predict(d);
      advance_model();
      vectors++;
      if ({spike_valid, spike_out} !== {1'b1, exp_s}) begin
         miscompares++;
         $display("FAIL clear_step0: got sv=%b so=%h, expected sv=1 so=%h", spike_valid, spike_out, exp_s);
      end
      @(negedge clk); step_en = 1'b1; clear = 1'b1; pixel_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({spike_valid, pixel_ready, busy, done, spike_out} !== {4'b0100, exp_s}) begin
         miscompares++;
         $display("FAIL clear_cycle: got sv=%b rdy=%b busy=%b done=%b so=%h, expected sv=0 rdy=1 busy=0 done=0 so=%h",
                  spike_valid, pixel_ready, busy, done, spike_out, exp_s);
      end
      @(negedge clk); step_en = 1'b0; clear = 1'b0; pixel_valid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({done, pixel_ready, busy} !== 3'b010) begin
         miscompares++;
         $display("FAIL clear_after: got done=%b rdy=%b busy=%b, expected done=0 rdy=1 busy=0", done, pixel_ready, busy);
      end
      load(d2, 8'd2);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); step_en = 1'b1;
         @(posedge clk); #1;
         exp_s = predict(d2);
         advance_model();
         vectors++;
         if ({spike_valid, spike_out, done} !== {1'b1, exp_s, (k == 1)}) begin
            miscompares++;
            $display("FAIL clear_new%0d: got sv=%b so=%h done=%b, expected sv=1 so=%h done=%b",
                     k, spike_valid, spike_out, done, exp_s, (k == 1));
         end
      end
      @(negedge clk); step_en = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] d2 = 64'hC0C0_C0C0_C0C0_C0C0;
      logic [7:0]  exp_s;
      load(64'hFFFF_FFFF_FFFF_FFFF, 8'd10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); step_en = 1'b1;
         @(posedge clk); #1;
         advance_model();
      end
      @(negedge clk); step_en = 1'b0; reset = 1'b1;
      #1;
      vectors++;
      if ({pixel_ready, busy, spike_out, spike_valid, done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL midrun_reset: got rdy=%b busy=%b so=%h sv=%b done=%b, expected rdy=1 busy=0 so=00 sv=0 done=0",
                  pixel_ready, busy, spike_out, spike_valid, done);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midrun_nodone: got done=%b busy=%b, expected done=0 busy=0", done, busy);
      end
      @(negedge clk); reset = 1'b0;
      reseed_model();
      load(d2, 8'd3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); step_en = 1'b1;
         @(posedge clk); #1;
         exp_s = predict(d2);
         advance_model();
         vectors++;
         if ({spike_valid, spike_out, done} !== {1'b1, exp_s, (k == 2)}) begin
            miscompares++;
            $display("FAIL reseed_step%0d: got sv=%b so=%h done=%b, expected sv=1 so=%h done=%b",
                     k, spike_valid, spike_out, done, exp_s, (k == 2));
         end
      end
      @(negedge clk); step_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_intensity();
      test_full_ch0();
      test_zero_steps();
      test_sparse();
      test_clear();
      test_reset_mid_run();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
